imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_imm_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : RV32I instruction encoder. Packs opcode, register fields,
//                function fields and a full-width immediate into a 32-bit
//                instruction word, range-checks the immediate for the
//                selected format, and queues the result in a 2-entry FIFO.
//                Illegal opcodes or out-of-range immediates are still
//                accepted. They push a NOP (addi x0,x0,0) flagged as an error.
//  Ports       :
//    clk         sole clock, rising edge
//    rst         synchronous active-high reset
//    in_valid    request valid
//    in_ready    FIFO has a free slot (occupancy < 2)
//    in_opcode   RV32I opcode, selects the format
//    in_rd/rs1/rs2  register fields
//    in_funct3/7 function fields
//    in_imm      signed full-width immediate
//    out_valid   head-of-FIFO word valid
//    out_ready   consumer takes the head word
//    out_instr   encoded instruction word (head of FIFO)
//    out_err     head word is an error substitute
//    enc_count   number of good words pushed (wraps)
//    err_count   number of error words pushed (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [6:0]       in_opcode,
    input  wire logic [4:0]       in_rd,
    input  wire logic [4:0]       in_rs1,
    input  wire logic [4:0]       in_rs2,
    input  wire logic [2:0]       in_funct3,
    input  wire logic [6:0]       in_funct7,
    input  wire logic [31:0]      in_imm,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic [31:0]           out_instr,
    output logic                  out_err,
    output logic [CNT_W-1:0]      enc_count,
    output logic [CNT_W-1:0]      err_count
);

    // ------------------------------------------------------------------
    // Opcodes and formats
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_BAD = 3'd7;

    // addi x0, x0, 0 -- substituted for any rejected request
    localparam logic [31:0]      c_NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Format decode
    // ------------------------------------------------------------------
    logic [2:0] w_fmt;

    always_comb begin
        w_fmt = c_FMT_BAD;
        case (in_opcode)
            c_OP_REG:                                      w_fmt = c_FMT_R;
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:   w_fmt = c_FMT_I;
            c_OP_STORE:                                    w_fmt = c_FMT_S;
            c_OP_BRANCH:                                   w_fmt = c_FMT_B;
            c_OP_LUI, c_OP_AUIPC:                          w_fmt = c_FMT_U;
            c_OP_JAL:                                      w_fmt = c_FMT_J;
            default:                                       w_fmt = c_FMT_BAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate range checks
    // A value fits an N-bit signed field when every bit from N-1 upward is
    // a copy of the sign, i.e. the upper slice is all-zero or all-one.
    // ------------------------------------------------------------------
    logic w_fits12;     // -2048 .. 2047
    logic w_fits13;     // -4096 .. 4095
    logic w_fits21;     // -1048576 .. 1048575
    logic w_even;
    logic w_low12_zero;
    logic w_shamt_ok;   // 0 .. 31
    logic w_is_shift;

    assign w_fits12     = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fits13     = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fits21     = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign w_even       = ~in_imm[0];
    assign w_low12_zero = ~(|in_imm[11:0]);
    assign w_shamt_ok   = ~(|in_imm[31:5]);
    // SLLI / SRLI / SRAI: funct3 001 or 101 under OP-IMM
    assign w_is_shift   = (in_opcode == c_OP_IMM) && (in_funct3[1:0] == 2'b01);

    // ------------------------------------------------------------------
    // Bit packing
    // ------------------------------------------------------------------
    logic [31:0] w_word;
    logic        w_ok;

    always_comb begin
        w_word = '0;
        w_ok   = 1'b0;
        case (w_fmt)
            c_FMT_R: begin
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                w_ok   = 1'b1;
            end
            c_FMT_I: begin
                if (w_is_shift) begin
                    // funct7 occupies the upper immediate bits, shamt below it
                    w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    w_ok   = w_shamt_ok;
                end else begin
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    w_ok   = w_fits12;
                end
            end
            c_FMT_S: begin
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_ok   = w_fits12;
            end
            c_FMT_B: begin
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
                w_ok   = w_fits13 & w_even;
            end
            c_FMT_U: begin
                w_word = {in_imm[31:12], in_rd, in_opcode};
                w_ok   = w_low12_zero;
            end
            c_FMT_J: begin
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
                w_ok   = w_fits21 & w_even;
            end
            default: begin
                w_word = '0;
                w_ok   = 1'b0;
            end
        endcase
    end

    // FIFO entry: {err, instr}
    logic [32:0] w_entry;
    assign w_entry = w_ok ? {1'b0, w_word} : {1'b1, c_NOP};

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // r_head is the output register; r_tail is the second slot. Keeping the
    // head in a dedicated register gives registered outputs and lets the
    // head hold its last value while the FIFO is empty.
    // ------------------------------------------------------------------
    logic [1:0]       r_occ;
    logic [32:0]      r_head;
    logic [32:0]      r_tail;
    logic [CNT_W-1:0] r_enc_count;
    logic [CNT_W-1:0] r_err_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_occ != 2'd2);
    assign out_valid = (r_occ != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ       <= 2'd0;
            r_head      <= '0;
            r_tail      <= '0;
            r_enc_count <= '0;
            r_err_count <= '0;
        end else begin
            case (r_occ)
                2'd0: begin
                    // pop is meaningless when empty
                    if (w_push) begin
                        r_head <= w_entry;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_entry;
                    end else if (w_push) begin
                        r_tail <= w_entry;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                2'd2: begin
                    // full: in_ready is low so no push can occur
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= 2'd1;
                    end
                end
                default: begin
                    r_occ <= 2'd0;
                end
            endcase

            if (w_push) begin
                if (w_entry[32]) begin
                    r_err_count <= r_err_count + c_CNT_ONE;
                end else begin
                    r_enc_count <= r_enc_count + c_CNT_ONE;
                end
            end
        end
    end

    assign out_instr = r_head[31:0];
    assign out_err   = r_head[32];
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Self-checking bench for imm_encoder. A queue-based model of
//                the encoder and its FIFO is compared against the DUT on
//                every falling edge; directed vectors add literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: encode from field definitions with shifts/masks and
    // range checks as signed integer comparisons. Returns {err, word}.
    // ------------------------------------------------------------------
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input int imm);
        logic [31:0] u;
        logic [31:0] base;
        logic [31:0] w;
        bit ok;
        u    = imm;
        base = {25'd0, op};
        w    = '0;
        ok   = 1'b0;
        case (op)
            7'h33: begin
                w  = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                     (32'(f3) << 12) | (32'(rd) << 7) | base;
                ok = 1'b1;
            end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (imm >= 0) && (imm <= 31);
                    w  = (32'(f7) << 25) | ((u & 32'h1F) << 20);
                end else begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    w  = (u & 32'hFFF) << 20;
                end
                w = w | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | base;
            end
            7'h23: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                     (32'(f3) << 12) | ((u & 32'h1F) << 7) | base;
            end
            7'h63: begin
                ok = (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
                w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                     (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
                     (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | base;
            end
            7'h37, 7'h17: begin
                ok = ((u & 32'hFFF) == 0);
                w  = (u & 32'hFFFF_F000) | (32'(rd) << 7) | base;
            end
            7'h6F: begin
                ok = (imm >= -1048576) && (imm <= 1048574) && ((imm % 2) == 0);
                w  = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                     (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                     (32'(rd) << 7) | base;
            end
            default: ok = 1'b0;
        endcase
        if (ok) return {1'b0, w};
        return {1'b1, 32'h0000_0013};
    endfunction

    // FIFO / counter model
    logic [32:0] mq[$];
    logic [32:0] m_last = '0;
    logic [15:0] m_enc  = '0;
    logic [15:0] m_err  = '0;
    bit          m_live = 1'b0;
    logic [31:0] seen[$];

    always @(posedge clk) begin
        bit          do_pop;
        bit          do_push;
        logic [32:0] e;
        if (rst) begin
            mq.delete();
            m_last = '0;
            m_enc  = '0;
            m_err  = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < 2);
            if (do_pop) m_last = mq.pop_front();
            if (do_push) begin
                e = model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
                              $signed(in_imm));
                mq.push_back(e);
                if (e[32]) m_err = m_err + 16'd1;
                else       m_enc = m_enc + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] exp_head;
        if (m_live) begin
            exp_head = (mq.size() > 0) ? mq[0] : m_last;
            chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("out_instr", 64'(out_instr), 64'(exp_head[31:0]));
            chk("out_err",   64'(out_err),   64'(exp_head[32]));
            chk("enc_count", 64'(enc_count), 64'(m_enc));
            chk("err_count", 64'(err_count), 64'(m_err));
            if (out_valid && out_ready) seen.push_back(out_instr);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after a rising edge.
    // send returns 1 unit after the edge at which the request was accepted.
    // ------------------------------------------------------------------
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input int imm);
        int n;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // Pin the model on hand-computed words
        chk("model_auipc", 64'(model_enc(7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000_0000)), 64'h0_1000_0297);
        chk("model_lw",    64'(model_enc(7'h03, 5'd6, 5'd6, 5'd0, 3'd2, 7'd0, -4)),  64'h0_FFC3_2303);
        chk("model_beq",   64'(model_enc(7'h63, 5'd0, 5'd6, 5'd0, 3'd0, 7'd0, 24)),  64'h0_0003_0C63);
        chk("model_jal",   64'(model_enc(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -20)), 64'h0_FEDF_F06F);
        chk("model_odd",   64'(model_enc(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13)),  64'h1_0000_0013);

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_enc",       64'(enc_count), 64'd0);

        // AUIPC, one cycle latency
        out_ready = 1'b1;
        send(7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000_0000);
        chk("auipc_valid", 64'(out_valid), 64'd1);
        chk("auipc_word",  64'(out_instr), 64'h1000_0297);
        chk("auipc_err",   64'(out_err),   64'd0);
        @(posedge clk); #1;

        // Back-to-back good instructions
        do_reset();
        send(7'h03, 5'd6, 5'd6, 5'd0, 3'd2, 7'd0, -4);
        chk("lw_word",  64'(out_instr), 64'hFFC3_2303);
        send(7'h63, 5'd0, 5'd6, 5'd0, 3'd0, 7'd0, 24);
        chk("beq_word", 64'(out_instr), 64'h0003_0C63);
        send(7'h63, 5'd0, 5'd6, 5'd5, 3'd4, 7'd0, 12);
        chk("blt_word", 64'(out_instr), 64'h0053_4663);
        send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -20);
        chk("jal_word", 64'(out_instr), 64'hFEDF_F06F);
        chk("enc_count_4", 64'(enc_count), 64'd4);
        @(posedge clk); #1;

        // Error substitutes and boundaries
        do_reset();
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13);
        chk("beq_odd_word", 64'(out_instr), 64'h13);
        chk("beq_odd_err",  64'(out_err),   64'd1);
        send(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2048);
        chk("addi_2048_word", 64'(out_instr), 64'h13);
        chk("addi_2048_err",  64'(out_err),   64'd1);
        send(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32);
        chk("slli_32_err", 64'(out_err), 64'd1);
        send(7'h7F, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 0);
        chk("bad_op_err", 64'(out_err), 64'd1);
        chk("err_count_4", 64'(err_count), 64'd4);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -2048);
        chk("addi_m2048_imm", 64'(out_instr[31:20]), 64'h800);
        chk("addi_m2048_err", 64'(out_err), 64'd0);
        send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1048574);
        chk("jal_max_word", 64'(out_instr), 64'h7FFF_F06F);
        chk("jal_max_err",  64'(out_err),   64'd0);
        send(7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 7);
        chk("srai_word", 64'(out_instr), 64'h4072_5193);
        send(7'h23, 5'd0, 5'd2, 5'd8, 3'd2, 7'd0, -8);
        chk("sw_word", 64'(out_instr), 64'hFE81_2C23);
        send(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        chk("lui_low_err", 64'(out_err), 64'd1);
        send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1048576);
        chk("jal_over_err", 64'(out_err), 64'd1);
        @(posedge clk); #1;

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        seen.delete();
        send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 0);
        send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 0);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        fork
            send(7'h33, 5'd1, 5'd2, 5'd3, 3'd4, 7'h00, 0);
            begin
                repeat (3) begin
                    chk("bp_hold_word",  64'(out_instr), 64'h0031_00B3);
                    chk("bp_hold_ready", 64'(in_ready),  64'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            chk("bp_order0", 64'(seen[0]), 64'h0031_00B3);
            chk("bp_order1", 64'(seen[1]), 64'h4031_00B3);
            chk("bp_order2", 64'(seen[2]), 64'h0031_40B3);
        end

        // Reset while full with a request pending
        do_reset();
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 2);
        in_opcode = 7'h13; in_rd = 5'd9; in_imm = 32'd5; in_funct3 = 3'd0;
        in_valid  = 1'b1;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        chk("rq_out_valid", 64'(out_valid), 64'd0);
        chk("rq_enc",       64'(enc_count), 64'd0);
        chk("rq_err",       64'(err_count), 64'd0);
        chk("rq_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rq_still_empty", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
